// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared types and constants for the core_ctrl sequencer
// Contents: FSM state enum, bit positions of the 34-bit core instruction word,
//           kernel base address in xmem, and the idle instruction word.
package core_ctrl_pkg;

    localparam int AW       = 11;   // xmem/pmem address width
    localparam int KERNEL_W = 3;    // kernel side; len_kij must equal KERNEL_W*KERNEL_W

    localparam int ACC_B      = 33;
    localparam int CEN_PMEM_B = 32;
    localparam int WEN_PMEM_B = 31;
    localparam int A_PMEM_LSB = 20;
    localparam int CEN_XMEM_B = 19;
    localparam int WEN_XMEM_B = 18;
    localparam int A_XMEM_LSB = 7;
    localparam int OFIFO_RD_B = 6;
    localparam int IFIFO_WR_B = 5;
    localparam int IFIFO_RD_B = 4;
    localparam int L0_RD_B    = 3;
    localparam int L0_WR_B    = 2;
    localparam int EXECUTE_B  = 1;
    localparam int LOAD_B     = 0;

    localparam logic [AW-1:0] XMEM_W_BASE = 11'd1024;

    // Both SRAMs deselected and in read mode; every strobe low.
    localparam logic [33:0] INST_IDLE = (34'd1 << CEN_PMEM_B) | (34'd1 << WEN_PMEM_B) |
                                        (34'd1 << CEN_XMEM_B) | (34'd1 << WEN_XMEM_B);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_L0,
        S_GAP1,
        S_LOAD,
        S_GAP2,
        S_X_L0,
        S_GAP3,
        S_EXEC,
        S_GAP4,
        S_DRAIN,
        S_GAP5,
        S_ACC,
        S_DONE
    } state_e;

endpackage

// File: rtl/core_ctrl_if.sv
// rtl/core_ctrl_if.sv - instruction bus between core_ctrl and core
// Signals: inst (34-bit instruction word, sequencer -> core),
//          ofifo_valid (core OFIFO has data, core -> sequencer).
// Modports: master = sequencer side, slave = core side.
interface core_ctrl_if;
    logic [33:0] inst;
    logic        ofifo_valid;

    modport master (output inst, input ofifo_valid);
    modport slave  (input inst, output ofifo_valid);
endinterface

// File: rtl/core_ctrl_addr.sv
// rtl/core_ctrl_addr.sv - pmem read address generator for the accumulate phase
// Ports: onij (output pixel index), k (kernel tap 0..8) -> a_pmem (11-bit address
//        of the partial sum for tap k that contributes to pixel onij).
module core_ctrl_addr
    import core_ctrl_pkg::*;
#(
    parameter int in_w  = 6,
    parameter int out_w = 4
) (
    input  logic [3:0]    onij,
    input  logic [3:0]    k,
    output logic [AW-1:0] a_pmem
);

    localparam logic [AW-1:0] IN_W    = AW'(in_w);
    localparam logic [AW-1:0] OUT_W   = AW'(out_w);
    localparam logic [AW-1:0] LEN_NIJ = AW'(in_w * in_w);
    localparam logic [AW-1:0] KS      = AW'(KERNEL_W);

    logic [AW-1:0] onij_w;
    logic [AW-1:0] k_w;
    logic [AW-1:0] o_r;
    logic [AW-1:0] o_c;

    // Partial sums of tap k sit in block k of pmem; inside the block the entry is the
    // input pixel the tap touches: row o_r+k/3, column o_c+k%3.
    always_comb begin
        onij_w = AW'(onij);
        k_w    = AW'(k);
        o_r    = onij_w / OUT_W;
        o_c    = onij_w % OUT_W;
        a_pmem = k_w * LEN_NIJ + (o_r + k_w / KS) * IN_W + (o_c + k_w % KS);
    end

endmodule

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - instruction sequencer running one 3x3 convolution tile on core
// Ports: clk, reset (async, active-low), start (pulse, accepted only when idle),
//        bus (master: inst out, ofifo_valid in), acc_clr, out_valid, onij_idx,
//        kij_idx, busy, done.
// Macro: CORE_CTRL_OFIFO_HANDSHAKE_EN - OFIFO reads in DRAIN are paced by ofifo_valid.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_kij = 9,
    parameter int in_w    = 6,
    parameter int out_w   = 4,
    parameter int gap     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    core_ctrl_if.master        bus,
    output logic               acc_clr,
    output logic               out_valid,
    output logic [3:0]         onij_idx,
    output logic [3:0]         kij_idx,
    output logic               busy,
    output logic               done
);

    localparam int LEN_NIJ_I  = in_w * in_w;
    localparam int LEN_ONIJ_I = out_w * out_w;
    localparam int EXEC_LEN_I = LEN_NIJ_I + row + col;

    if ((1024 + len_kij * col - 1 > 2047) || (len_kij * LEN_NIJ_I - 1 > 2047) ||
        (EXEC_LEN_I > 2047) || (gap < 1) || (col < 1) ||
        (len_kij != KERNEL_W * KERNEL_W) || (LEN_ONIJ_I > 16) ||
        (in_w < out_w + KERNEL_W - 1)) begin : g_bad_params
        $error("core_ctrl: parameter set overflows 11-bit addressing or breaks the 3x3 tile");
    end

    localparam logic [AW-1:0] COL       = AW'(col);
    localparam logic [AW-1:0] COL_M1    = AW'(col - 1);
    localparam logic [AW-1:0] GAP_M1    = AW'(gap - 1);
    localparam logic [AW-1:0] LEN_NIJ   = AW'(LEN_NIJ_I);
    localparam logic [AW-1:0] LEN_NIJ_M1 = AW'(LEN_NIJ_I - 1);
    localparam logic [AW-1:0] EXEC_M1   = AW'(EXEC_LEN_I - 1);
    localparam logic [AW-1:0] LEN_KIJ   = AW'(len_kij);
    // ACC slot per pixel: clear, len_kij reads, one trailing acc, out_valid.
    localparam logic [AW-1:0] ACC_LAST  = AW'(len_kij + 2);
    localparam logic [3:0]    KIJ_LAST  = 4'(len_kij - 1);
    localparam logic [3:0]    ONIJ_LAST = 4'(LEN_ONIJ_I - 1);

    state_e        state, nxt_state;
    logic [AW-1:0] cnt, nxt_cnt;
    logic [3:0]    kij, nxt_kij;
    logic [3:0]    onij, nxt_onij;
    logic [33:0]   inst_q, nxt_inst;
    logic [AW-1:0] acc_addr;
    logic          rd_now;

    // rd_now: an OFIFO entry is popped on the coming edge.
`ifdef CORE_CTRL_OFIFO_HANDSHAKE_EN
    assign rd_now = (state == S_DRAIN) && bus.ofifo_valid && (cnt < LEN_NIJ);
    // The read strobe follows ofifo_valid in the same cycle so an empty FIFO is never popped.
    assign bus.inst = inst_q | ({33'd0, rd_now} << OFIFO_RD_B);
`else
    logic unused_ofifo_valid;
    assign unused_ofifo_valid = bus.ofifo_valid;
    assign rd_now   = (state == S_DRAIN) && (cnt < LEN_NIJ);
    assign bus.inst = inst_q;
`endif

    // Address for the ACC read that will be on the bus in the next cycle (tap = slot-1).
    core_ctrl_addr #(.in_w(in_w), .out_w(out_w)) u_addr (
        .onij   (nxt_onij),
        .k      (4'(nxt_cnt - AW'(1))),
        .a_pmem (acc_addr)
    );

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + AW'(1);
        nxt_kij   = kij;
        nxt_onij  = onij;
        unique case (state)
            S_IDLE: begin
                nxt_cnt = '0;
                if (start) begin
                    nxt_state = S_W_L0;
                    nxt_kij   = '0;
                    nxt_onij  = '0;
                end
            end
            S_W_L0:  if (cnt == COL_M1)     begin nxt_state = S_GAP1;  nxt_cnt = '0; end
            S_GAP1:  if (cnt == GAP_M1)     begin nxt_state = S_LOAD;  nxt_cnt = '0; end
            S_LOAD:  if (cnt == COL_M1)     begin nxt_state = S_GAP2;  nxt_cnt = '0; end
            S_GAP2:  if (cnt == GAP_M1)     begin nxt_state = S_X_L0;  nxt_cnt = '0; end
            S_X_L0:  if (cnt == LEN_NIJ_M1) begin nxt_state = S_GAP3;  nxt_cnt = '0; end
            S_GAP3:  if (cnt == GAP_M1)     begin nxt_state = S_EXEC;  nxt_cnt = '0; end
            S_EXEC:  if (cnt == EXEC_M1)    begin nxt_state = S_GAP4;  nxt_cnt = '0; end
            S_GAP4:  if (cnt == GAP_M1)     begin nxt_state = S_DRAIN; nxt_cnt = '0; end
            S_DRAIN: begin
                // cnt counts reads; reaching len_nij means the last write is on the bus now.
                nxt_cnt = cnt + AW'(rd_now);
                if (cnt == LEN_NIJ) begin
                    nxt_state = S_GAP5;
                    nxt_cnt   = '0;
                end
            end
            S_GAP5: begin
                if (cnt == GAP_M1) begin
                    nxt_cnt = '0;
                    if (kij == KIJ_LAST) begin
                        nxt_state = S_ACC;
                        nxt_onij  = '0;
                    end else begin
                        nxt_state = S_W_L0;
                        nxt_kij   = kij + 4'd1;
                    end
                end
            end
            S_ACC: begin
                if (cnt == ACC_LAST) begin
                    nxt_cnt = '0;
                    if (onij == ONIJ_LAST) nxt_state = S_DONE;
                    else                   nxt_onij  = onij + 4'd1;
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Instruction word for the cycle described by nxt_state/nxt_cnt.
    always_comb begin
        nxt_inst = INST_IDLE;
        unique case (nxt_state)
            S_W_L0: begin
                nxt_inst[CEN_XMEM_B]          = 1'b0;
                nxt_inst[A_XMEM_LSB +: AW]    = XMEM_W_BASE + AW'(nxt_kij) * COL + nxt_cnt;
                nxt_inst[L0_WR_B]             = 1'b1;
            end
            S_LOAD: begin
                nxt_inst[L0_RD_B]             = 1'b1;
                nxt_inst[LOAD_B]              = 1'b1;
            end
            S_X_L0: begin
                nxt_inst[CEN_XMEM_B]          = 1'b0;
                nxt_inst[A_XMEM_LSB +: AW]    = nxt_cnt;
                nxt_inst[L0_WR_B]             = 1'b1;
            end
            S_EXEC: begin
                nxt_inst[EXECUTE_B]           = 1'b1;
                nxt_inst[L0_RD_B]             = (nxt_cnt < LEN_NIJ);
            end
            S_DRAIN: begin
`ifndef CORE_CTRL_OFIFO_HANDSHAKE_EN
                nxt_inst[OFIFO_RD_B]          = (nxt_cnt < LEN_NIJ);
`endif
                // Entry popped this cycle is written to pmem in the next one.
                if (rd_now) begin
                    nxt_inst[CEN_PMEM_B]      = 1'b0;
                    nxt_inst[WEN_PMEM_B]      = 1'b0;
                    nxt_inst[A_PMEM_LSB +: AW] = AW'(nxt_kij) * LEN_NIJ + cnt;
                end
            end
            S_ACC: begin
                if ((nxt_cnt >= AW'(1)) && (nxt_cnt <= LEN_KIJ)) begin
                    nxt_inst[CEN_PMEM_B]      = 1'b0;
                    nxt_inst[A_PMEM_LSB +: AW] = acc_addr;
                end
                // pmem data arrives one cycle after its address.
                if ((nxt_cnt >= AW'(2)) && (nxt_cnt <= LEN_KIJ + AW'(1))) begin
                    nxt_inst[ACC_B]           = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            kij       <= '0;
            onij      <= '0;
            inst_q    <= INST_IDLE;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            kij       <= nxt_kij;
            onij      <= nxt_onij;
            inst_q    <= nxt_inst;
            acc_clr   <= (nxt_state == S_ACC) && (nxt_cnt == '0);
            out_valid <= (nxt_state == S_ACC) && (nxt_cnt == ACC_LAST);
            busy      <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done      <= (nxt_state == S_DONE);
        end
    end

    assign onij_idx = onij;
    assign kij_idx  = kij;

endmodule
